// File: rtl/wb_xbar_pipe.sv
// wb_xbar_pipe: single-master, NS-slave pipelined Wishbone crossbar.
// Each accepted request pushes its target tag into a small in-order FIFO.
// Responses are taken only from the slave named by the head tag. Requests
// that hit no slave are answered with wbm_err one cycle after they reach the
// head. Define WB_XBAR_TIMEOUT_EN to add a watchdog that errors out a head
// entry whose slave stays silent for TIMEOUT cycles.
module wb_xbar_pipe #(
  parameter int NS      = 5,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int DEPTH   = 4,
  parameter logic [NS-1:0][AW-1:0] BASE = {16'h7000, 16'h6000, 16'h5000, 16'h4000, 16'h0000},
  parameter logic [NS-1:0][AW-1:0] MASK = {16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'hE000},
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wbm_cyc,
  input  logic             wbm_stb,
  input  logic             wbm_we,
  input  logic [AW-1:0]    wbm_adr,
  input  logic [DW-1:0]    wbm_dat_i,
  output logic [DW-1:0]    wbm_dat_o,
  output logic             wbm_ack,
  output logic             wbm_err,
  output logic             wbm_stall,
  output logic [NS-1:0]    wbs_cyc,
  output logic [NS-1:0]    wbs_stb,
  output logic [NS-1:0]    wbs_we,
  output logic [AW-1:0]    wbs_adr,
  output logic [DW-1:0]    wbs_dat_o,
  input  logic [NS*DW-1:0] wbs_dat_i,
  input  logic [NS-1:0]    wbs_ack,
  input  logic [NS-1:0]    wbs_stall
);

  localparam int TW = $clog2(NS + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] UNMAPPED = TW'(NS);

  logic [1:0]    rstSync_q;
  logic          live;
  logic [NS-1:0] sel;
  logic [TW-1:0] tgt;
  logic          hitStall;
  logic [TW-1:0] tagMem_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] lastTag_q, lastTag_d;
  logic          errArm_q, errArm_d;
  logic [TW-1:0] headTag;
  logic          headAck;
  logic [DW-1:0] headDat;
  logic          empty, full, blk, accept, pop, toErr;
  logic [NS-1:0] owns;

  // Reset asserts immediately but is released only after two clean edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rstSync_q <= 2'b00;
    else        rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign live = rstSync_q[1];

  // Address decode: lowest-index matching window wins, otherwise unmapped
  always_comb begin
    sel = '0;
    tgt = UNMAPPED;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((wbm_adr & MASK[i]) == BASE[i]) begin
        sel = '0;
        sel[i] = 1'b1;
        tgt = TW'(i);
      end
    end
  end

  assign hitStall = |(sel & wbs_stall);
  assign headTag  = tagMem_q[rdPtr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

  // Response mux driven only by the slave at the head of the tag FIFO
  always_comb begin
    headAck = 1'b0;
    headDat = '0;
    for (int i = 0; i < NS; i++) begin
      if (headTag == TW'(i)) begin
        headAck = wbs_ack[i];
        headDat = wbs_dat_i[i*DW +: DW];
      end
    end
  end

  assign wbm_err   = live & wbm_cyc & (errArm_q | toErr);
  assign wbm_ack   = live & wbm_cyc & !empty & headAck & !wbm_err;
  assign wbm_dat_o = wbm_ack ? headDat : '0;
  assign pop       = wbm_ack | wbm_err;

  // A full FIFO only admits a request when the head leaves in the same cycle;
  // switching slaves waits until every earlier request has been answered.
  assign blk       = (full & !pop) | (!empty & (tgt != lastTag_q));
  assign wbm_stall = live ? (blk | hitStall) : hitStall;
  assign accept    = live & wbm_cyc & wbm_stb & !wbm_stall;

  // Slave-side controls; outstanding entries all share the last pushed tag
  always_comb begin
    owns = '0;
    for (int i = 0; i < NS; i++) begin
      owns[i] = !empty & (lastTag_q == TW'(i));
    end
  end

  assign wbs_stb   = (live & wbm_cyc & wbm_stb & !blk) ? sel : '0;
  assign wbs_cyc   = (live & wbm_cyc) ? (sel | owns) : '0;
  assign wbs_we    = wbm_we ? wbs_cyc : '0;
  assign wbs_adr   = wbm_adr;
  assign wbs_dat_o = wbm_dat_i;

  // Tag FIFO storage needs no reset: entries are qualified by the occupancy
  always_ff @(posedge clk) begin
    if (accept) tagMem_q[wrPtr_q] <= tgt;
  end

  // Next-state for pointers, occupancy and the unmapped-error arm
  always_comb begin
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    count_d   = count_q;
    lastTag_d = lastTag_q;
    errArm_d  = 1'b0;
    if (!live || !wbm_cyc) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (accept) begin
        wrPtr_d   = wrPtr_q + PW'(1);
        lastTag_d = tgt;
      end
      if (pop) rdPtr_d = rdPtr_q + PW'(1);
      count_d  = count_q + CW'(accept) - CW'(pop);
      errArm_d = !empty && (headTag == UNMAPPED) && !errArm_q;
    end
  end

  // FIFO control registers, cleared while reset or its release is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
      lastTag_q <= UNMAPPED;
      errArm_q  <= 1'b0;
    end else begin
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
      lastTag_q <= lastTag_d;
      errArm_q  <= errArm_d;
    end
  end

`ifdef WB_XBAR_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 1);

  logic [TOW-1:0] toCnt_q, toCnt_d;
  logic           toErr_q, toErr_d;

  // Watchdog counts silent cycles at the head and fires a one-cycle error
  always_comb begin
    toCnt_d = toCnt_q;
    toErr_d = 1'b0;
    if (!live || !wbm_cyc || empty || pop) begin
      toCnt_d = '0;
    end else if (toCnt_q == TOW'(TIMEOUT - 1)) begin
      toCnt_d = '0;
      toErr_d = 1'b1;
    end else begin
      toCnt_d = toCnt_q + TOW'(1);
    end
  end

  // Watchdog state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toCnt_q <= '0;
      toErr_q <= 1'b0;
    end else begin
      toCnt_q <= toCnt_d;
      toErr_q <= toErr_d;
    end
  end

  assign toErr = toErr_q;
`else
  logic unusedTimeout;

  assign unusedTimeout = (TIMEOUT == 0);
  assign toErr         = 1'b0;
`endif

endmodule

// File: tb/tb_wb_xbar_pipe.sv
// tb_wb_xbar_pipe: randomized bench for wb_xbar_pipe (default build).
// The reference model keeps the outstanding requests as an ordered queue of
// (target, address) and derives stall, strobes and responses from the
// crossbar's ordering rules; slaves answer reads with a data word computed
// from their index and the request address.
module tb_wb_xbar_pipe;

  localparam int NS    = 5;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wbm_cyc, wbm_stb, wbm_we;
  logic [AW-1:0]    wbm_adr;
  logic [DW-1:0]    wbm_dat_i, wbm_dat_o;
  logic             wbm_ack, wbm_err, wbm_stall;
  logic [NS-1:0]    wbs_cyc, wbs_stb, wbs_we;
  logic [AW-1:0]    wbs_adr;
  logic [DW-1:0]    wbs_dat_o;
  logic [NS*DW-1:0] wbs_dat_i;
  logic [NS-1:0]    wbs_ack, wbs_stall;

  typedef struct {
    int            tgt;
    logic [AW-1:0] adr;
  } req_t;

  req_t expQ[$];
  int   headAge;
  int   lastT;
  int   ackPct;
  int   nCompared;
  int   nMismatched;

  always #5 clk = ~clk;

  wb_xbar_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wbm_cyc   (wbm_cyc),
    .wbm_stb   (wbm_stb),
    .wbm_we    (wbm_we),
    .wbm_adr   (wbm_adr),
    .wbm_dat_i (wbm_dat_i),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack   (wbm_ack),
    .wbm_err   (wbm_err),
    .wbm_stall (wbm_stall),
    .wbs_cyc   (wbs_cyc),
    .wbs_stb   (wbs_stb),
    .wbs_we    (wbs_we),
    .wbs_adr   (wbs_adr),
    .wbs_dat_o (wbs_dat_o),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack   (wbs_ack),
    .wbs_stall (wbs_stall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Address map written as plain ranges; NS means no slave claims it
  function automatic int refTarget(input logic [AW-1:0] a);
    if (a < 16'h2000) return 0;
    if (a >= 16'h4000 && a < 16'h4800) return 1;
    if (a >= 16'h5000 && a < 16'h5800) return 2;
    if (a >= 16'h6000 && a < 16'h6800) return 3;
    if (a >= 16'h7000 && a < 16'h7800) return 4;
    return NS;
  endfunction

  function automatic logic [DW-1:0] slvData(input int s, input logic [AW-1:0] a);
    return a ^ DW'(16'h1111 * (s + 1));
  endfunction

  task automatic genAddress(input int t, output logic [AW-1:0] a);
    case (t)
      0:       a = AW'($urandom_range(16'h1FFF));
      1:       a = 16'h4000 | AW'($urandom_range(16'h07FF));
      2:       a = 16'h5000 | AW'($urandom_range(16'h07FF));
      3:       a = 16'h6000 | AW'($urandom_range(16'h07FF));
      4:       a = 16'h7000 | AW'($urandom_range(16'h07FF));
      default: begin
        case ($urandom_range(2))
          0:       a = 16'h8000 | AW'($urandom_range(16'h7FFF));
          1:       a = 16'h2000 | AW'($urandom_range(16'h1FFF));
          default: a = 16'h4800 | AW'($urandom_range(16'h07FF));
        endcase
      end
    endcase
  endtask

  task automatic applyStimulus();
    int hs;
    if (wbm_cyc) begin
      if ($urandom_range(59) == 0) wbm_cyc = 1'b0;
    end else if ($urandom_range(2) == 0) begin
      wbm_cyc = 1'b1;
    end
    wbm_stb   = ($urandom_range(99) < 70);
    wbm_we    = 1'($urandom_range(1));
    if ($urandom_range(3) == 0) lastT = int'($urandom_range(NS));
    genAddress(lastT, wbm_adr);
    wbm_dat_i = DW'($urandom);
    hs = (expQ.size() > 0 && expQ[0].tgt < NS) ? expQ[0].tgt : -1;
    for (int i = 0; i < NS; i++) begin
      wbs_stall[i] = ($urandom_range(3) == 0);
      wbs_dat_i[i*DW +: DW] = DW'($urandom);
      if (i == hs) begin
        wbs_ack[i] = ($urandom_range(99) < ackPct);
        if (wbs_ack[i]) wbs_dat_i[i*DW +: DW] = slvData(i, expQ[0].adr);
      end else begin
        wbs_ack[i] = ($urandom_range(7) == 0);
      end
    end
  endtask

  task automatic evalCycle();
    int            t;
    int            qlen;
    logic          eAck, eErr, pop, blk, eStall;
    logic [NS-1:0] eStb, eCyc;
    logic [DW-1:0] eDat;
    t    = refTarget(wbm_adr);
    qlen = expQ.size();
    eAck = 1'b0;
    eErr = 1'b0;
    if (wbm_cyc && qlen > 0) begin
      if (expQ[0].tgt < NS) eAck = wbs_ack[expQ[0].tgt];
      else                  eErr = (headAge == 1);
    end
    pop = eAck || eErr;
    blk = (qlen == DEPTH) && !pop;
    if (qlen > 0 && t != expQ[qlen-1].tgt) blk = 1'b1;
    eStall = blk || (t < NS && wbs_stall[t]);
    eStb = '0;
    if (wbm_cyc && wbm_stb && t < NS && !blk) eStb[t] = 1'b1;
    eCyc = '0;
    if (wbm_cyc) begin
      if (t < NS) eCyc[t] = 1'b1;
      foreach (expQ[k]) if (expQ[k].tgt < NS) eCyc[expQ[k].tgt] = 1'b1;
    end
    eDat = eAck ? slvData(expQ[0].tgt, expQ[0].adr) : '0;
    checkOutput("wbmStall", 32'(wbm_stall), 32'(eStall));
    checkOutput("wbmAck",   32'(wbm_ack),   32'(eAck));
    checkOutput("wbmErr",   32'(wbm_err),   32'(eErr));
    checkOutput("wbmDat",   32'(wbm_dat_o), 32'(eDat));
    checkOutput("wbsStb",   32'(wbs_stb),   32'(eStb));
    checkOutput("wbsCyc",   32'(wbs_cyc),   32'(eCyc));
    checkOutput("wbsWe",    32'(wbs_we),    32'(wbm_we ? eCyc : '0));
    checkOutput("wbsAdr",   32'(wbs_adr),   32'(wbm_adr));
    checkOutput("wbsDat",   32'(wbs_dat_o), 32'(wbm_dat_i));
    if (!wbm_cyc) begin
      expQ.delete();
      headAge = 0;
    end else begin
      if (pop) begin
        void'(expQ.pop_front());
        headAge = 0;
      end else if (qlen > 0) begin
        headAge++;
      end
      if (wbm_stb && !eStall) expQ.push_back('{tgt: t, adr: wbm_adr});
    end
  endtask

  // Outputs must be quiet in reset; stall mirrors only the decoded slave
  task automatic resetChecks(input string tag);
    int t;
    t = refTarget(wbm_adr);
    checkOutput({tag, "Ack"},   32'(wbm_ack),   32'(0));
    checkOutput({tag, "Err"},   32'(wbm_err),   32'(0));
    checkOutput({tag, "Dat"},   32'(wbm_dat_o), 32'(0));
    checkOutput({tag, "Cyc"},   32'(wbs_cyc),   32'(0));
    checkOutput({tag, "Stb"},   32'(wbs_stb),   32'(0));
    checkOutput({tag, "Stall"}, 32'(wbm_stall), 32'((t < NS) ? wbs_stall[t] : 1'b0));
  endtask

  task automatic releaseReset();
    expQ.delete();
    headAge = 0;
    wbm_cyc = 1'b0;
    wbm_stb = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    int pctTable [3] = '{50, 5, 90};
    nCompared   = 0;
    nMismatched = 0;
    headAge     = 0;
    lastT       = 1;
    ackPct      = 50;
    rst_n       = 1'b0;
    wbm_cyc     = 1'b1;
    wbm_stb     = 1'b1;
    wbm_we      = 1'b0;
    wbm_adr     = 16'h4000;
    wbm_dat_i   = 16'hA5A5;
    wbs_dat_i   = {NS{16'h1234}};
    wbs_ack     = '1;
    wbs_stall   = 5'b00010;
    #3 resetChecks("rstHitStall");
    wbs_stall = 5'b00000;
    #1 resetChecks("rstHitFree");
    wbm_adr   = 16'h8000;
    wbs_stall = '1;
    #1 resetChecks("rstUnmapped");
    releaseReset();

    for (int ph = 0; ph < 3; ph++) begin
      ackPct = pctTable[ph];
      for (int c = 0; c < 600; c++) begin
        @(posedge clk);
        #1 applyStimulus();
        if (ph == 1 && c == 300) begin
          rst_n = 1'b0;
          #1 resetChecks("midRst");
          releaseReset();
        end else begin
          #1 evalCycle();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
